// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 types and constants for the multiplier arbiter
// Purpose: common width, FP32 word type and handy constants.
// Ports: none (package).
package fp_pkg;

  localparam int FP_W = 32;

  typedef logic [FP_W-1:0] fp32_t;

  localparam fp32_t FP_ONE  = 32'h3F80_0000;
  localparam fp32_t FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp32_mul.sv
// rtl/fp32_mul.sv - combinational IEEE-754 single-precision multiplier
// Purpose: product of two FP32 operands, round-to-nearest-even.
//   Subnormal inputs and results are flushed to signed zero.
// Ports:
//   a_i, b_i : FP32 operands
//   p_o      : FP32 product
module fp32_mul
  import fp_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t p_o
);

  logic               sgn;
  logic [7:0]         ea, eb;
  logic [22:0]        ma, mb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic signed [9:0]  exp_sum;
  logic signed [9:0]  exp_n;
  logic [22:0]        mant;
  logic               guard, sticky, inc;
  logic [23:0]        mant_r;

  assign sgn = a_i[31] ^ b_i[31];
  assign ea  = a_i[30:23];
  assign eb  = b_i[30:23];
  assign ma  = a_i[22:0];
  assign mb  = b_i[22:0];

  assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  assign prod    = 48'({1'b1, ma}) * 48'({1'b1, mb});
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  always_comb begin
    mant   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    inc    = 1'b0;
    mant_r = '0;
    exp_n  = exp_sum;
    p_o    = FP_ZERO;

    // Product of two [1,2) significands lies in [1,4): normalise by one bit if needed.
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_sum + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    inc    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, inc};
    // Rounding carry out of the fraction bumps the exponent; fraction is then zero.
    if (mant_r[23]) begin
      exp_n = exp_n + 10'sd1;
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p_o = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      p_o = {sgn, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      p_o = {sgn, 31'd0};
    end else if (exp_n >= 10'sd255) begin
      p_o = {sgn, 8'hFF, 23'd0};
    end else if (exp_n <= 10'sd0) begin
      p_o = {sgn, 31'd0};
    end else begin
      p_o = {sgn, exp_n[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selector
// Purpose: pick the first asserted request at or after the pointer, wrapping.
// Ports:
//   req_i : request vector
//   ptr_i : highest-priority index this cycle
//   en_i  : grant enable; no grant when low
//   gnt_o : one-hot grant (zero when nothing granted)
//   idx_o : encoded index of the granted request
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   sel;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < N; k++) begin
      sel = (int'(ptr_i) + k) % N;
      if (en_i && !found && req_i[IW'(sel)]) begin
        found             = 1'b1;
        gnt_o[IW'(sel)]   = 1'b1;
        idx_o             = IW'(sel);
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin shared FP32 multiplier with 2-stage pipeline
// Purpose: grants one requester per cycle, registers its operands (S0),
//   multiplies and registers the tagged product (S1) under backpressure.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester operand handshake (ready one-hot or zero)
//   req_a, req_b        : flattened FP32 operands, requester i at [32i+31:32i]
//   res_valid/res_ready : result handshake
//   res_data, res_id    : FP32 product and issuing requester index
//   busy                : either pipeline stage holds a valid entry
//   ops_done            : wrapping count of results accepted downstream
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [FP_W-1:0]         res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        ops_done
);

  logic             s0_valid_q, s0_valid_d;
  fp32_t            s0_a_q, s0_a_d;
  fp32_t            s0_b_q, s0_b_d;
  logic [ID_W-1:0]  s0_id_q, s0_id_d;
  logic             res_valid_q, res_valid_d;
  fp32_t            res_data_q, res_data_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic             s1_adv, s0_adv;
  logic             arb_en, xfer;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  fp32_t            prod;

  assign s1_adv = !res_valid_q || res_ready;
  assign s0_adv = !s0_valid_q || s1_adv;

  // Gate with rst_n so no grant is offered while reset is held.
  assign arb_en = s0_adv && rst_n;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  // Grants are only issued to valid requesters, so any grant is a transfer.
  assign xfer      = |gnt;
  assign req_ready = gnt;

  fp32_mul u_mut (
    .a_i (s0_a_q),
    .b_i (s0_b_q),
    .p_o (prod)
  );

  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_a_d      = s0_a_q;
    s0_b_d      = s0_b_q;
    s0_id_d     = s0_id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    ops_d       = ops_q;

    if (s0_adv) begin
      s0_valid_d = xfer;
      if (xfer) begin
        s0_a_d  = req_a[gnt_idx*FP_W +: FP_W];
        s0_b_d  = req_b[gnt_idx*FP_W +: FP_W];
        s0_id_d = gnt_idx;
        if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gnt_idx + ID_W'(1);
        end
      end
    end

    if (s1_adv) begin
      res_valid_d = s0_valid_q;
      res_data_d  = prod;
      res_id_d    = s0_id_q;
    end

    if (res_valid_q && res_ready) begin
      ops_d = ops_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s0_a_q      <= FP_ZERO;
      s0_b_q      <= FP_ZERO;
      s0_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= FP_ZERO;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
      ops_q       <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_a_q      <= s0_a_d;
      s0_b_q      <= s0_b_d;
      s0_id_q     <= s0_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
      ops_q       <= ops_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s0_valid_q || res_valid_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter
module tb_fp_mul_arbiter;
  import fp_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [IW-1:0]     res_id;
  logic              busy;
  logic [CW-1:0]     ops_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IW),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  typedef struct {
    int    r;
    fp32_t a;
    fp32_t b;
    fp32_t p;
  } vec_t;

  vec_t  vecs [8];
  fp32_t rr_p [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_op(input int r, input fp32_t a, input fp32_t b);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    vecs[1] = '{1, 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000};
    vecs[2] = '{2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
    vecs[3] = '{3, FP_ONE,        FP_ONE,        FP_ONE};
    vecs[4] = '{0, 32'h4080_0000, 32'h3E80_0000, FP_ONE};
    vecs[5] = '{1, 32'hC040_0000, 32'hC040_0000, 32'h4110_0000};
    vecs[6] = '{2, FP_ZERO,       32'h40A0_0000, FP_ZERO};
    vecs[7] = '{3, FP_ONE,        32'h42F6_0000, 32'h42F6_0000};
    rr_p[0] = 32'h4000_0000;
    rr_p[1] = 32'h4080_0000;
    rr_p[2] = 32'h40C0_0000;
    rr_p[3] = 32'h4100_0000;

    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;

    // Reset state, with every requester asking.
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_ops_done",  32'(ops_done),  32'h0);
    check("rst_res_data",  res_data,       32'h0);
    check("rst_res_id",    32'(res_id),    32'h0);
    drive_slot();
    rst_n = 1'b1;

    // Round robin: all four valid, operands i+1.0 times 2.0.
    set_op(0, 32'h3F80_0000, 32'h4000_0000);
    set_op(1, 32'h4000_0000, 32'h4000_0000);
    set_op(2, 32'h4040_0000, 32'h4000_0000);
    set_op(3, 32'h4080_0000, 32'h4000_0000);
    req_valid = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c < 10) check($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2 && c < 12) begin
        check($sformatf("rr_valid_c%0d", c), 32'(res_valid), 32'h1);
        check($sformatf("rr_id_c%0d", c),    32'(res_id),    32'((c - 2) % 4));
        check($sformatf("rr_data_c%0d", c),  res_data,       rr_p[(c - 2) % 4]);
      end
      if (c == 12) begin
        check("rr_drain_valid", 32'(res_valid), 32'h0);
        check("rr_drain_busy",  32'(busy),      32'h0);
        check("rr_ops_done",    32'(ops_done),  32'd10);
      end
      drive_slot();
      if (c == 9) req_valid = '0;
    end

    // Table: single ops through each requester, latency 2.
    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].r, vecs[i].a, vecs[i].b);
      req_valid = 4'(1 << vecs[i].r);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << vecs[i].r));
      drive_slot();
      req_valid = '0;
      @(negedge clk);
      check($sformatf("vec%0d_lat1", i), 32'(res_valid), 32'h0);
      drive_slot();
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(res_valid), 32'h1);
      check($sformatf("vec%0d_data", i),  res_data,       vecs[i].p);
      check($sformatf("vec%0d_id", i),    32'(res_id),    32'(vecs[i].r));
      drive_slot();
    end
    @(negedge clk);
    check("tbl_ops_done_wrap", 32'(ops_done), 32'd2);
    drive_slot();

    // Backpressure: three requesters with the output stalled.
    res_ready = 1'b0;
    set_op(0, 32'h4000_0000, 32'h4040_0000);
    set_op(1, 32'h3FC0_0000, 32'h3FC0_0000);
    set_op(2, 32'hC000_0000, 32'h3F00_0000);
    req_valid = 4'b0111;
    @(negedge clk);
    check("bp_grant0", 32'(req_ready), 32'b0001);
    drive_slot();
    req_valid = 4'b0110;
    @(negedge clk);
    check("bp_grant1",  32'(req_ready), 32'b0010);
    check("bp_s1_empty", 32'(res_valid), 32'h0);
    drive_slot();
    req_valid = 4'b0100;
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_stall_ready_c%0d", c), 32'(req_ready), 32'h0);
      check($sformatf("bp_stall_valid_c%0d", c), 32'(res_valid), 32'h1);
      check($sformatf("bp_stall_id_c%0d", c),    32'(res_id),    32'h0);
      check($sformatf("bp_stall_busy_c%0d", c),  32'(busy),      32'h1);
      drive_slot();
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_grant2", 32'(req_ready), 32'b0100);
    check("bp_res0_id",       32'(res_id),    32'h0);
    check("bp_res0_data",     res_data,       32'h40C0_0000);
    drive_slot();
    req_valid = '0;
    @(negedge clk);
    check("bp_res1_id",   32'(res_id), 32'h1);
    check("bp_res1_data", res_data,    32'h4010_0000);
    drive_slot();
    @(negedge clk);
    check("bp_res2_id",   32'(res_id), 32'h2);
    check("bp_res2_data", res_data,    32'hBF80_0000);
    drive_slot();
    @(negedge clk);
    check("bp_drained",  32'(res_valid), 32'h0);
    check("bp_ops_done", 32'(ops_done),  32'd5);
    drive_slot();

    // Reset mid-flight: two entries held, then asynchronous reset.
    res_ready = 1'b0;
    set_op(3, 32'h4000_0000, 32'h4000_0000);
    set_op(2, 32'h4040_0000, 32'h4000_0000);
    req_valid = 4'b1100;
    @(negedge clk);
    check("mr_grant3", 32'(req_ready), 32'b1000);
    drive_slot();
    req_valid = 4'b0100;
    @(negedge clk);
    check("mr_grant2", 32'(req_ready), 32'b0100);
    drive_slot();
    req_valid = '0;
    @(negedge clk);
    check("mr_full_busy", 32'(busy), 32'h1);
    set_op(0, FP_ONE, FP_ONE);
    set_op(1, FP_ONE, FP_ONE);
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_res_valid", 32'(res_valid), 32'h0);
    check("mr_busy",      32'(busy),      32'h0);
    check("mr_ops_done",  32'(ops_done),  32'h0);
    check("mr_req_ready", 32'(req_ready), 32'h0);
    drive_slot();
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check("mr_first_grant", 32'(req_ready), 32'b0001);
    check("mr_discarded",   32'(res_valid), 32'h0);
    drive_slot();
    req_valid = '0;
    @(negedge clk);
    check("mr_lat1", 32'(res_valid), 32'h0);
    drive_slot();
    @(negedge clk);
    check("mr_res_valid2", 32'(res_valid), 32'h1);
    check("mr_res_id",     32'(res_id),    32'h0);
    check("mr_res_data",   res_data,       FP_ONE);
    drive_slot();
    @(negedge clk);
    check("mr_ops_one", 32'(ops_done), 32'd1);
    drive_slot();

    // Counter wrap: 16 more results on a 4-bit counter, 17 in total.
    req_valid = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check($sformatf("wrap_grant_c%0d", c), 32'(req_ready), 32'b0001);
      drive_slot();
      if (c == 15) req_valid = '0;
    end
    @(negedge clk);
    check("wrap_ops_15", 32'(ops_done), 32'd15);
    drive_slot();
    @(negedge clk);
    check("wrap_ops_0", 32'(ops_done), 32'd0);
    drive_slot();
    @(negedge clk);
    check("wrap_ops_1",  32'(ops_done), 32'd1);
    check("wrap_idle",   32'(busy),     32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
